// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the hazard / pipeline-control block: the destination-metadata
// bundle carried through the pipeline registers, its bubble value and the FSM states.
package pipe_ctrl_pkg;

    // Register index width carried in the bundle; the top-level REG_ADDR_W must match.
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } dest_ctrl_t;

    // All-zero bundle: no control bits, no register indices, never matches a forwarding compare.
    localparam dest_ctrl_t BUBBLE = '0;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the instruction in ID reads the destination of a load in ID/EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_ex_rd,
    input  logic                  i_id_ex_memread,
    output logic                  o_lu_stall
);

    logic w_match;

    // x0 loads are excluded: x0 is never a real dependency.
    always_comb begin
        w_match    = (i_id_uses_rs1 && (i_id_rs1 == i_id_ex_rd)) ||
                     (i_id_uses_rs2 && (i_id_rs2 == i_id_ex_rd));
        o_lu_stall = i_id_valid && i_id_ex_memread && (i_id_ex_rd != '0) && w_match;
    end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline destination-metadata tracking plus stall / flush / freeze control for
// load-use, taken-branch and data-memory-wait hazards.
module hazard_pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] id_ex_rs1,
    output logic [REG_ADDR_W-1:0] id_ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  ex_mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_wb_rd,
    output logic                  mem_wb_regwrite,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cycles
);

    dest_ctrl_t            r_id_ex;
    logic [REG_ADDR_W-1:0] r_ex_mem_rd;
    logic                  r_ex_mem_regwrite;
    logic                  r_ex_mem_memread;
    logic                  r_ex_mem_memwrite;
    logic [REG_ADDR_W-1:0] r_mem_wb_rd;
    logic                  r_mem_wb_regwrite;
    logic [CNT_W-1:0]      r_stall_cycles;
    state_t                r_state;

    state_t                w_state_next;
    dest_ctrl_t            w_id_fields;
    logic                  w_lu_stall;
    logic                  w_freeze;
    logic                  w_flush;
    logic                  w_stall;
    logic                  w_id_ex_bubble;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_id_valid      (id_valid),
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_uses_rs1   (id_uses_rs1),
        .i_id_uses_rs2   (id_uses_rs2),
        .i_id_ex_rd      (r_id_ex.rd),
        .i_id_ex_memread (r_id_ex.memread),
        .o_lu_stall      (w_lu_stall)
    );

    // Hazard priority (freeze > flush > load-use) and the zero-latency hold/flush enables.
    always_comb begin
        w_freeze         = (r_ex_mem_memread || r_ex_mem_memwrite) && !mem_ready;
        w_flush          = ex_branch_taken && !w_freeze;
        w_stall          = w_lu_stall && !w_freeze && !w_flush;
        w_id_ex_bubble   = w_flush || w_stall || !id_valid;
        pc_write         = !(w_freeze || w_stall);
        if_id_write      = !(w_freeze || w_stall);
        if_id_flush      = w_flush;
        w_id_fields      = BUBBLE;
        w_id_fields.rd   = id_rd;
        w_id_fields.rs1  = id_rs1;
        w_id_fields.rs2  = id_rs2;
        w_id_fields.regwrite = id_regwrite;
        w_id_fields.memread  = id_memread;
        w_id_fields.memwrite = id_memwrite;
    end

    // Memory-wait FSM next state; the freeze itself is decoded above in both states.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:      if (w_freeze)  w_state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready) w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pipeline registers: freeze holds ID/EX and EX/MEM and drains a bubble into MEM/WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_ex           <= BUBBLE;
            r_ex_mem_rd       <= '0;
            r_ex_mem_regwrite <= 1'b0;
            r_ex_mem_memread  <= 1'b0;
            r_ex_mem_memwrite <= 1'b0;
            r_mem_wb_rd       <= '0;
            r_mem_wb_regwrite <= 1'b0;
        end else if (w_freeze) begin
            r_mem_wb_rd       <= '0;
            r_mem_wb_regwrite <= 1'b0;
        end else begin
            r_id_ex           <= w_id_ex_bubble ? BUBBLE : w_id_fields;
            r_ex_mem_rd       <= r_id_ex.rd;
            r_ex_mem_regwrite <= r_id_ex.regwrite;
            r_ex_mem_memread  <= r_id_ex.memread;
            r_ex_mem_memwrite <= r_id_ex.memwrite;
            r_mem_wb_rd       <= r_ex_mem_rd;
            r_mem_wb_regwrite <= r_ex_mem_regwrite;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!pc_write && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign id_ex_rs1       = r_id_ex.rs1;
    assign id_ex_rs2       = r_id_ex.rs2;
    assign ex_mem_rd       = r_ex_mem_rd;
    assign ex_mem_regwrite = r_ex_mem_regwrite;
    assign mem_wb_rd       = r_mem_wb_rd;
    assign mem_wb_regwrite = r_mem_wb_regwrite;
    assign stall_cycles    = r_stall_cycles;

endmodule
